// File: rtl/vga_pkg.sv
// Shared raster-timing definitions: standard mode constants, axis-total helpers,
// the 32-bit coordinate type and the registered strobe bundle.
package vga_pkg;

   typedef logic [31:0] coord_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank_n;
      logic sync_n;
      logic disp_enable;
   } strobe_t;

   // 1280x1024@60, 108 MHz pixel clock
   localparam int unsigned SXGA_H_DISP  = 1280;
   localparam int unsigned SXGA_H_FRONT = 48;
   localparam int unsigned SXGA_H_SYNC  = 112;
   localparam int unsigned SXGA_H_BACK  = 248;
   localparam int unsigned SXGA_V_DISP  = 1024;
   localparam int unsigned SXGA_V_FRONT = 1;
   localparam int unsigned SXGA_V_SYNC  = 3;
   localparam int unsigned SXGA_V_BACK  = 38;

   // 640x480@60, 25.175 MHz pixel clock
   localparam int unsigned VGA_H_DISP   = 640;
   localparam int unsigned VGA_H_FRONT  = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BACK   = 48;
   localparam int unsigned VGA_V_DISP   = 480;
   localparam int unsigned VGA_V_FRONT  = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BACK   = 33;

   function automatic int unsigned axis_total(input int unsigned disp,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return disp + front + sync + back;
   endfunction

   function automatic int unsigned h_total(input int unsigned h_disp,
                                           input int unsigned h_front,
                                           input int unsigned h_sync,
                                           input int unsigned h_back);
      return axis_total(h_disp, h_front, h_sync, h_back);
   endfunction

   function automatic int unsigned v_total(input int unsigned v_disp,
                                           input int unsigned v_front,
                                           input int unsigned v_sync,
                                           input int unsigned v_back);
      return axis_total(v_disp, v_front, v_sync, v_back);
   endfunction

   // Strobe levels held while in reset: syncs inactive at their own polarity, blanked.
   function automatic strobe_t strobe_idle(input logic hs_pol, input logic vs_pol);
      strobe_t s;
      s.hsync       = ~hs_pol;
      s.vsync       = ~vs_pol;
      s.blank_n     = 1'b0;
      s.sync_n      = 1'b1;
      s.disp_enable = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with advance enable, plus the
// in-display and in-sync window flags decoded from the current count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned DISP  = 1,
   parameter int unsigned FRONT = 1,
   parameter int unsigned SYNC  = 1,
   parameter int unsigned BACK  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv_i,
   output logic [31:0] cnt_o,
   output logic        in_disp_o,
   output logic        in_sync_o
);

   localparam int unsigned TOTAL   = axis_total(DISP, FRONT, SYNC, BACK);
   localparam coord_t      LAST    = coord_t'(TOTAL - 1);
   localparam coord_t      DISP_HI = coord_t'(DISP);
   localparam coord_t      SYNC_LO = coord_t'(DISP + FRONT);
   localparam coord_t      SYNC_HI = coord_t'(DISP + FRONT + SYNC);

   coord_t cnt_q;
   coord_t cnt_d;

   // NOTE: cnt_d gets a default before any branch; a path that left it unassigned would infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (adv_i) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + coord_t'(1);
         end
      end
   end

   // NOTE: state is updated with <= so all flops see pre-edge values; reset is synchronous, sampled on clk like data.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign in_disp_o = (cnt_q < DISP_HI);
   assign in_sync_o = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: registered coordinates and sync/blank strobes, all aligned.
// Optional frame_start output enabled by defining VGA_TIMING_FRAME_START_EN.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_disp  = SXGA_H_DISP,
   parameter int unsigned H_front = SXGA_H_FRONT,
   parameter int unsigned H_sync  = SXGA_H_SYNC,
   parameter int unsigned H_back  = SXGA_H_BACK,
   parameter int unsigned V_disp  = SXGA_V_DISP,
   parameter int unsigned V_front = SXGA_V_FRONT,
   parameter int unsigned V_sync  = SXGA_V_SYNC,
   parameter int unsigned V_back  = SXGA_V_BACK,
   parameter logic        HS_POL  = 1'b0,
   parameter logic        VS_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
`ifdef VGA_TIMING_FRAME_START_EN
   output logic        frame_start,
`endif
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic        sync_n,
   output logic        disp_enable,
   output logic [31:0] Xpix,
   output logic [31:0] Ypix
);

   localparam coord_t H_LAST = coord_t'(h_total(H_disp, H_front, H_sync, H_back) - 1);

   coord_t  h_cnt;
   coord_t  v_cnt;
   logic    h_in_disp;
   logic    h_in_sync;
   logic    v_in_disp;
   logic    v_in_sync;
   logic    h_last;

   coord_t  xpix_q;
   coord_t  ypix_q;
   strobe_t strobe_q;
   strobe_t strobe_d;

   // The counters hold the position about to be presented; the output
   // registers below present it one clock later with its decoded strobes.
   vga_axis_counter #(
      .DISP  (H_disp),
      .FRONT (H_front),
      .SYNC  (H_sync),
      .BACK  (H_back)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .adv_i     (1'b1),
      .cnt_o     (h_cnt),
      .in_disp_o (h_in_disp),
      .in_sync_o (h_in_sync)
   );

   assign h_last = (h_cnt == H_LAST);

   vga_axis_counter #(
      .DISP  (V_disp),
      .FRONT (V_front),
      .SYNC  (V_sync),
      .BACK  (V_back)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .adv_i     (h_last),
      .cnt_o     (v_cnt),
      .in_disp_o (v_in_disp),
      .in_sync_o (v_in_sync)
   );

   always_comb begin
      strobe_d             = strobe_idle(HS_POL, VS_POL);
      strobe_d.disp_enable = h_in_disp && v_in_disp;
      strobe_d.blank_n     = h_in_disp && v_in_disp;
      strobe_d.hsync       = h_in_sync ? HS_POL : ~HS_POL;
      strobe_d.vsync       = v_in_sync ? VS_POL : ~VS_POL;
      // Composite sync is always active-low, whatever the per-axis polarities.
      strobe_d.sync_n      = ~(h_in_sync || v_in_sync);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xpix_q   <= '0;
         ypix_q   <= '0;
         strobe_q <= strobe_idle(HS_POL, VS_POL);
      end else begin
         xpix_q   <= h_cnt;
         ypix_q   <= v_cnt;
         strobe_q <= strobe_d;
      end
   end

`ifdef VGA_TIMING_FRAME_START_EN
   logic frame_start_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

   assign frame_start = frame_start_q;
`endif

   assign Xpix        = xpix_q;
   assign Ypix        = ypix_q;
   assign hsync       = strobe_q.hsync;
   assign vsync       = strobe_q.vsync;
   assign blank_n     = strobe_q.blank_n;
   assign sync_n      = strobe_q.sync_n;
   assign disp_enable = strobe_q.disp_enable;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: 640x480 line vectors, 1280x1024 line window,
// and a scoreboarded miniature raster covering whole frames and mid-frame reset.
module tb_vga_timing;
   import vga_pkg::*;

   localparam int unsigned S_HD = 16, S_HF = 2, S_HS = 3, S_HB = 4;
   localparam int unsigned S_VD = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
   localparam int unsigned S_HT = 25, S_VT = 12, S_FRAME = 300;
   localparam int unsigned RST_AT_K = S_FRAME + 5 * S_HT + 7;
   localparam int unsigned RUN = 1800;

   typedef struct {
      int unsigned x;
      int unsigned y;
      logic de, hs, vs, sn, bn, fs;
   } exp_t;

   typedef struct {
      int unsigned cyc;
      int unsigned x;
      int unsigned y;
      logic de, hs, vs, sn, fs;
   } vvec_t;

   logic clk, rst, rst_s;
   logic hs_v, vs_v, bn_v, sn_v, de_v;
   logic hs_x, vs_x, bn_x, sn_x, de_x;
   logic hs_s, vs_s, bn_s, sn_s, de_s;
   logic [31:0] x_v, y_v, x_x, y_x, x_s, y_s;
`ifdef VGA_TIMING_FRAME_START_EN
   logic fs_v, fs_x, fs_s;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t sb[$];
   vvec_t vtab[13];

   vga_timing #(
      .H_disp(VGA_H_DISP), .H_front(VGA_H_FRONT), .H_sync(VGA_H_SYNC), .H_back(VGA_H_BACK),
      .V_disp(VGA_V_DISP), .V_front(VGA_V_FRONT), .V_sync(VGA_V_SYNC), .V_back(VGA_V_BACK),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_vga (
      .clk(clk), .rst(rst),
`ifdef VGA_TIMING_FRAME_START_EN
      .frame_start(fs_v),
`endif
      .hsync(hs_v), .vsync(vs_v), .blank_n(bn_v), .sync_n(sn_v),
      .disp_enable(de_v), .Xpix(x_v), .Ypix(y_v)
   );

   vga_timing u_sxga (
      .clk(clk), .rst(rst),
`ifdef VGA_TIMING_FRAME_START_EN
      .frame_start(fs_x),
`endif
      .hsync(hs_x), .vsync(vs_x), .blank_n(bn_x), .sync_n(sn_x),
      .disp_enable(de_x), .Xpix(x_x), .Ypix(y_x)
   );

   vga_timing #(
      .H_disp(S_HD), .H_front(S_HF), .H_sync(S_HS), .H_back(S_HB),
      .V_disp(S_VD), .V_front(S_VF), .V_sync(S_VS), .V_back(S_VB),
      .HS_POL(1'b1), .VS_POL(1'b0)
   ) u_small (
      .clk(clk), .rst(rst_s),
`ifdef VGA_TIMING_FRAME_START_EN
      .frame_start(fs_s),
`endif
      .hsync(hs_s), .vsync(vs_s), .blank_n(bn_s), .sync_n(sn_s),
      .disp_enable(de_s), .Xpix(x_s), .Ypix(y_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Expected miniature-raster outputs k clocks after reset release (hsync active-high).
   function automatic exp_t model_small(input int unsigned k);
      exp_t e;
      logic hin, vin;
      e.x  = k % S_HT;
      e.y  = (k / S_HT) % S_VT;
      hin  = (e.x >= S_HD + S_HF) && (e.x < S_HD + S_HF + S_HS);
      vin  = (e.y >= S_VD + S_VF) && (e.y < S_VD + S_VF + S_VS);
      e.de = (e.x < S_HD) && (e.y < S_VD);
      e.bn = e.de;
      e.hs = hin;
      e.vs = !vin;
      e.sn = !(hin || vin);
`ifdef VGA_TIMING_FRAME_START_EN
      e.fs = (k % S_FRAME) == 0;
`else
      e.fs = 1'b0;
`endif
      return e;
   endfunction

   function automatic exp_t idle_small();
      exp_t e;
      e.x = 0; e.y = 0;
      e.de = 1'b0; e.bn = 1'b0; e.hs = 1'b0; e.vs = 1'b1; e.sn = 1'b1; e.fs = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] pack_exp(input exp_t e);
      logic [31:0] px, py;
      px = e.x;
      py = e.y;
      return {px[11:0], py[11:0], e.de, e.hs, e.vs, e.sn, e.bn, e.fs, 2'b00};
   endfunction

   function automatic logic [31:0] pack_small();
      logic fs;
`ifdef VGA_TIMING_FRAME_START_EN
      fs = fs_s;
`else
      fs = 1'b0;
`endif
      return {x_s[11:0], y_s[11:0], de_s, hs_s, vs_s, sn_s, bn_s, fs, 2'b00};
   endfunction

   task automatic sb_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty when output expected", tag);
      end else begin
         e = sb.pop_front();
         check(tag, pack_small(), pack_exp(e));
      end
   endtask

   initial begin
      int unsigned k;
      int          last_org;
      int unsigned rst_phase;
      int unsigned vi;
      int unsigned v_de_cnt, v_hs_cnt, v_hs_first, v_hs_last;
      int unsigned x_hs_cnt, x_hs_first, x_hs_last;

      //            cyc    x    y  de hs vs sn fs
      vtab[0]  = '{   0,   0,   0, 1, 1, 1, 1, 1};
      vtab[1]  = '{ 639, 639,   0, 1, 1, 1, 1, 0};
      vtab[2]  = '{ 640, 640,   0, 0, 1, 1, 1, 0};
      vtab[3]  = '{ 655, 655,   0, 0, 1, 1, 1, 0};
      vtab[4]  = '{ 656, 656,   0, 0, 0, 1, 0, 0};
      vtab[5]  = '{ 751, 751,   0, 0, 0, 1, 0, 0};
      vtab[6]  = '{ 752, 752,   0, 0, 1, 1, 1, 0};
      vtab[7]  = '{ 799, 799,   0, 0, 1, 1, 1, 0};
      vtab[8]  = '{ 800,   0,   1, 1, 1, 1, 1, 0};
      vtab[9]  = '{ 810,  10,   1, 1, 1, 1, 1, 0};
      vtab[10] = '{1500, 700,   1, 0, 0, 1, 0, 0};
      vtab[11] = '{1599, 799,   1, 0, 1, 1, 1, 0};
      vtab[12] = '{1600,   0,   2, 1, 1, 1, 1, 0};

      rst = 1'b1;
      rst_s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(idle_small());
         @(negedge clk);
         sb_compare($sformatf("small reset cyc%0d", i));
      end
      check("vga reset Xpix", x_v, 0);
      check("vga reset Ypix", y_v, 0);
      check("vga reset disp_enable", de_v, 0);
      check("vga reset blank_n", bn_v, 0);
      check("vga reset hsync", hs_v, 1);
      check("vga reset vsync", vs_v, 1);
      check("vga reset sync_n", sn_v, 1);
      check("sxga reset hsync", hs_x, 1);
      check("sxga reset disp_enable", de_x, 0);
`ifdef VGA_TIMING_FRAME_START_EN
      check("vga reset frame_start", fs_v, 0);
`endif

      rst = 1'b0;
      rst_s = 1'b0;
      k = 0;
      sb.push_back(model_small(0));
      last_org = -1;
      rst_phase = 0;
      vi = 0;
      v_de_cnt = 0; v_hs_cnt = 0; v_hs_first = 0; v_hs_last = 0;
      x_hs_cnt = 0; x_hs_first = 0; x_hs_last = 0;

      for (int n = 0; n < RUN; n++) begin
         @(negedge clk);
         sb_compare($sformatf("small n%0d k%0d", n, k));

         while (vi < 13 && vtab[vi].cyc == n) begin
            check($sformatf("vga n%0d Xpix", n), x_v, vtab[vi].x);
            check($sformatf("vga n%0d Ypix", n), y_v, vtab[vi].y);
            check($sformatf("vga n%0d disp_enable", n), de_v, vtab[vi].de);
            check($sformatf("vga n%0d blank_n", n), bn_v, vtab[vi].de);
            check($sformatf("vga n%0d hsync", n), hs_v, vtab[vi].hs);
            check($sformatf("vga n%0d vsync", n), vs_v, vtab[vi].vs);
            check($sformatf("vga n%0d sync_n", n), sn_v, vtab[vi].sn);
`ifdef VGA_TIMING_FRAME_START_EN
            check($sformatf("vga n%0d frame_start", n), fs_v, vtab[vi].fs);
`endif
            vi++;
         end

         if (n < 800) begin
            if (de_v) v_de_cnt++;
            if (!hs_v) begin
               if (v_hs_cnt == 0) v_hs_first = x_v;
               v_hs_last = x_v;
               v_hs_cnt++;
            end
         end
         if (n < 1688 && !hs_x) begin
            if (x_hs_cnt == 0) x_hs_first = x_x;
            x_hs_last = x_x;
            x_hs_cnt++;
         end
         if (n == 0) begin
            check("sxga first Xpix", x_x, 0);
            check("sxga first disp_enable", de_x, 1);
`ifdef VGA_TIMING_FRAME_START_EN
            check("sxga first frame_start", fs_x, 1);
`endif
         end
         if (n == 1688) begin
            check("sxga wrap Xpix", x_x, 0);
            check("sxga wrap Ypix", y_x, 1);
`ifdef VGA_TIMING_FRAME_START_EN
            check("sxga line2 frame_start", fs_x, 0);
`endif
         end

         if (x_s == 0 && y_s == 0 && de_s) begin
            if (last_org >= 0) check($sformatf("small frame length n%0d", n), n - last_org, S_FRAME);
            last_org = n;
         end

         if (rst_phase == 1) begin
            check("midreset Xpix", x_s, 0);
            check("midreset Ypix", y_s, 0);
            check("midreset disp_enable", de_s, 0);
            rst_s = 1'b0;
            k = 0;
            sb.push_back(model_small(0));
            rst_phase = 2;
         end else begin
            if (rst_phase == 2) begin
               check("post-midreset Xpix", x_s, 0);
               check("post-midreset Ypix", y_s, 0);
               check("post-midreset disp_enable", de_s, 1);
               rst_phase = 0;
            end
            if (k == RST_AT_K) begin
               rst_s = 1'b1;
               rst_phase = 1;
               last_org = -1;
               k = k + 1;
               sb.push_back(idle_small());
            end else begin
               k = k + 1;
               sb.push_back(model_small(k));
            end
         end
      end

      check("vga line disp_enable count", v_de_cnt, 640);
      check("vga line hsync low count", v_hs_cnt, 96);
      check("vga hsync first Xpix", v_hs_first, 656);
      check("vga hsync last Xpix", v_hs_last, 751);
      check("sxga hsync low count", x_hs_cnt, 112);
      check("sxga hsync first Xpix", x_hs_first, 1328);
      check("sxga hsync last Xpix", x_hs_last, 1439);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
